sdrc_app_wr_fifo: RTL and testbench

- Application-side write-data staging buffer. It sits directly upstream of the SDRAM bus-width converter and feeds its app_wr_data / app_wr_en_n inputs.
- It pops one application word per app_wr_next and tracks burst boundaries so the request side only issues a write command once a complete burst is buffered.
- It flags underrun and burst-length mismatch conditions.

---
 rtl/sdrc_pkg.sv | 30 +++
 rtl/sdrc_app_wr_fifo_if.sv | 18 +
 rtl/sdrc_fifo_ram.sv | 26 ++
 rtl/sdrc_app_wr_fifo.sv | 134 +++++++++++++
 tb/tb_sdrc_app_wr_fifo.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/sdrc_pkg.sv
// Shared constants and types for the SDRAM application-side write path.
package sdrc_pkg;

  localparam int APP_DW_DEF = 32;
  localparam int APP_BW_DEF = 4;
  localparam int ENTRY_W    = APP_DW_DEF + APP_BW_DEF + 1;

  // One stored word: burst-last flag, active-low byte enables, data.
  typedef struct packed {
    logic                  last;
    logic [APP_BW_DEF-1:0] en_n;
    logic [APP_DW_DEF-1:0] data;
  } entry_t;

  // Head values presented while the buffer is empty: no bytes written.
  localparam logic [APP_DW_DEF-1:0] EMPTY_DATA = {APP_DW_DEF{1'b0}};
  localparam logic [APP_BW_DEF-1:0] EMPTY_EN_N = {APP_BW_DEF{1'b1}};

  // Build a storage entry from its fields.
  function automatic entry_t pack_entry(input logic last,
                                        input logic [APP_BW_DEF-1:0] en_n,
                                        input logic [APP_DW_DEF-1:0] data);
    entry_t e;
    e.last = last;
    e.en_n = en_n;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/sdrc_app_wr_fifo_if.sv
// Upstream write-word handshake into the application write buffer.
interface sdrc_app_wr_fifo_if
  import sdrc_pkg::*;
#(
  parameter int DW = APP_DW_DEF,
  parameter int BW = APP_BW_DEF
);
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic [BW-1:0] wr_en_n;
  logic          wr_last;

  modport master (output wr_valid, output wr_data, output wr_en_n, output wr_last,
                  input  wr_ready);
  modport slave  (input  wr_valid, input  wr_data, input  wr_en_n, input  wr_last,
                  output wr_ready);
endinterface

// File: rtl/sdrc_fifo_ram.sv
// Register array with one write port and one asynchronous read port.
module sdrc_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 37
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Storage write; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sdrc_app_wr_fifo.sv
// Application write-data staging FIFO: first-word fall-through head,
// complete-burst counting, and sticky underrun / last-flag mismatch errors.
module sdrc_app_wr_fifo
  import sdrc_pkg::*;
#(
  parameter int APP_DW = APP_DW_DEF,
  parameter int APP_BW = APP_BW_DEF,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              reset,
  sdrc_app_wr_fifo_if.slave wr_if,
  output logic [APP_DW-1:0] app_wr_data,
  output logic [APP_BW-1:0] app_wr_en_n,
  input  logic              app_wr_next,
  input  logic              app_last_wr,
  output logic              burst_avail,
  output logic [AW:0]       burst_cnt,
  output logic [AW:0]       level,
  output logic              err_underrun,
  output logic              err_last_mis,
  input  logic              err_clr
);

  localparam int            EW       = APP_DW + APP_BW + 1;
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ZERO_LVL = {(AW+1){1'b0}};
  localparam logic [AW:0]   ONE_LVL  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ONE_PTR  = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d, bcnt_q, bcnt_d;
  logic          wr_ready_q, wr_ready_d;
  logic          err_un_q, err_un_d, err_mis_q, err_mis_d;
  logic          push_s, pop_s, empty_s, head_last_s;
  logic [EW-1:0] head_s, wentry_s;

  // Handshakes: wr_ready is a register, so pop never reaches it combinationally.
  assign empty_s     = (level_q == ZERO_LVL);
  assign push_s      = wr_if.wr_valid & wr_ready_q;
  assign pop_s       = app_wr_next & ~empty_s;
  assign wentry_s    = {wr_if.wr_last, wr_if.wr_en_n, wr_if.wr_data};
  assign head_last_s = head_s[EW-1];

  sdrc_fifo_ram #(.DEPTH(DEPTH), .AW(AW), .W(EW)) u_ram (
    .clk     (clk),
    .we_i    (push_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (wentry_s),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_s)
  );

  // Fall-through head; empty buffer presents data 0 with all bytes disabled.
  always_comb begin
    app_wr_data = APP_DW'(EMPTY_DATA);
    app_wr_en_n = APP_BW'(EMPTY_EN_N);
    if (!empty_s) begin
      app_wr_data = head_s[APP_DW-1:0];
      app_wr_en_n = head_s[APP_DW +: APP_BW];
    end else begin
      app_wr_data = APP_DW'(EMPTY_DATA);
      app_wr_en_n = APP_BW'(EMPTY_EN_N);
    end
  end

  // Next-state for pointers, occupancy, burst count, errors and ready.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    bcnt_d   = bcnt_q;

    if (push_s) wr_ptr_d = wr_ptr_q + ONE_PTR;
    else        wr_ptr_d = wr_ptr_q;

    if (pop_s) rd_ptr_d = rd_ptr_q + ONE_PTR;
    else       rd_ptr_d = rd_ptr_q;

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + ONE_LVL;
      2'b01:   level_d = level_q - ONE_LVL;
      default: level_d = level_q;
    endcase

    // Burst count follows the stored last flag, never app_last_wr.
    case ({push_s & wr_if.wr_last, pop_s & head_last_s})
      2'b10:   bcnt_d = bcnt_q + ONE_LVL;
      2'b01:   bcnt_d = bcnt_q - ONE_LVL;
      default: bcnt_d = bcnt_q;
    endcase

    // Sticky errors: a new event wins over a same-cycle clear.
    if (app_wr_next & empty_s) err_un_d = 1'b1;
    else if (err_clr)          err_un_d = 1'b0;
    else                       err_un_d = err_un_q;

    if (pop_s & (app_last_wr != head_last_s)) err_mis_d = 1'b1;
    else if (err_clr)                         err_mis_d = 1'b0;
    else                                      err_mis_d = err_mis_q;

    wr_ready_d = (level_d != FULL_LVL);
  end

  // State registers with synchronous reset; memory contents are not cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      level_q    <= ZERO_LVL;
      bcnt_q     <= ZERO_LVL;
      wr_ready_q <= 1'b1;
      err_un_q   <= 1'b0;
      err_mis_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      bcnt_q     <= bcnt_d;
      wr_ready_q <= wr_ready_d;
      err_un_q   <= err_un_d;
      err_mis_q  <= err_mis_d;
    end
  end

  assign wr_if.wr_ready = wr_ready_q;
  assign level          = level_q;
  assign burst_cnt      = bcnt_q;
  assign burst_avail    = (bcnt_q != ZERO_LVL);
  assign err_underrun   = err_un_q;
  assign err_last_mis   = err_mis_q;

endmodule

// File: tb/tb_sdrc_app_wr_fifo.sv
// Self-checking bench for sdrc_app_wr_fifo: directed vector table, corner
// sequences and a randomized run against a queue-based reference model.
module tb_sdrc_app_wr_fifo;
  import sdrc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] app_wr_data;
  logic [3:0]  app_wr_en_n;
  logic        app_wr_next, app_last_wr, err_clr;
  logic        burst_avail, err_underrun, err_last_mis;
  logic [4:0]  burst_cnt, level;

  sdrc_app_wr_fifo_if ifc ();

  sdrc_app_wr_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .wr_if        (ifc),
    .app_wr_data  (app_wr_data),
    .app_wr_en_n  (app_wr_en_n),
    .app_wr_next  (app_wr_next),
    .app_last_wr  (app_last_wr),
    .burst_avail  (burst_avail),
    .burst_cnt    (burst_cnt),
    .level        (level),
    .err_underrun (err_underrun),
    .err_last_mis (err_last_mis),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored words plus sticky flags.
  entry_t mq[$];
  bit     m_un, m_mis, m_ready;
  int     errors = 0;
  int     checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int m_bursts();
    int n = 0;
    foreach (mq[i]) if (mq[i].last) n++;
    return n;
  endfunction

  task automatic check_model();
    chk("level", 32'(level), 32'(mq.size()));
    chk("burst_cnt", 32'(burst_cnt), 32'(m_bursts()));
    chk("burst_avail", 32'(burst_avail), 32'(m_bursts() != 0));
    chk("wr_ready", 32'(ifc.wr_ready), 32'(m_ready));
    chk("err_underrun", 32'(err_underrun), 32'(m_un));
    chk("err_last_mis", 32'(err_last_mis), 32'(m_mis));
    if (mq.size() != 0) begin
      chk("head_data", app_wr_data, mq[0].data);
      chk("head_en_n", 32'(app_wr_en_n), 32'(mq[0].en_n));
    end else begin
      chk("head_data_empty", app_wr_data, 32'h0);
      chk("head_en_n_empty", 32'(app_wr_en_n), 32'hF);
    end
  endtask

  // One clock: drive inputs, advance the model, check after the edge.
  task automatic step(input bit rst, input bit v, input logic [31:0] d,
                      input logic [3:0] e, input bit l, input bit nx,
                      input bit al, input bit clr);
    bit     was_empty, pushed, popped;
    entry_t ent;
    reset = rst; ifc.wr_valid = v; ifc.wr_data = d; ifc.wr_en_n = e;
    ifc.wr_last = l; app_wr_next = nx; app_last_wr = al; err_clr = clr;
    if (rst) begin
      mq.delete(); m_un = 1'b0; m_mis = 1'b0; m_ready = 1'b1;
    end else begin
      was_empty = (mq.size() == 0);
      pushed    = v && m_ready;
      popped    = nx && !was_empty;
      if (nx && was_empty) m_un = 1'b1;
      else if (clr)        m_un = 1'b0;
      if (popped && (al != mq[0].last)) m_mis = 1'b1;
      else if (clr)                     m_mis = 1'b0;
      if (popped) void'(mq.pop_front());
      if (pushed) begin
        ent = pack_entry(l, e, d);
        mq.push_back(ent);
      end
      m_ready = (mq.size() != 16);
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic push(input logic [31:0] d, input bit l);
    step(0, 1, d, 4'h0, l, 0, 0, 0);
  endtask

  task automatic pop_ok();
    step(0, 0, 32'h0, 4'h0, 0, 1, (mq.size() != 0) ? mq[0].last : 1'b0, 0);
  endtask

  typedef struct {
    bit          rst, v, l, nx, al;
    logic [31:0] d;
    logic [4:0]  x_level, x_bcnt;
    logic [31:0] x_data;
    logic [3:0]  x_en;
  } vec_t;

  vec_t tbl[9];

  initial begin
    reset = 1'b1; ifc.wr_valid = 1'b0; ifc.wr_data = 32'h0; ifc.wr_en_n = 4'h0;
    ifc.wr_last = 1'b0; app_wr_next = 1'b0; app_last_wr = 1'b0; err_clr = 1'b0;
    m_ready = 1'b1;

    // Directed burst of four words in and out.
    tbl[0] = '{1,0,0,0,0, 32'h0,        5'd0, 5'd0, 32'h0,        4'hF};
    tbl[1] = '{0,1,0,0,0, 32'h11111111, 5'd1, 5'd0, 32'h11111111, 4'h0};
    tbl[2] = '{0,1,0,0,0, 32'h22222222, 5'd2, 5'd0, 32'h11111111, 4'h0};
    tbl[3] = '{0,1,0,0,0, 32'h33333333, 5'd3, 5'd0, 32'h11111111, 4'h0};
    tbl[4] = '{0,1,1,0,0, 32'h44444444, 5'd4, 5'd1, 32'h11111111, 4'h0};
    tbl[5] = '{0,0,0,1,0, 32'h0,        5'd3, 5'd1, 32'h22222222, 4'h0};
    tbl[6] = '{0,0,0,1,0, 32'h0,        5'd2, 5'd1, 32'h33333333, 4'h0};
    tbl[7] = '{0,0,0,1,0, 32'h0,        5'd1, 5'd1, 32'h44444444, 4'h0};
    tbl[8] = '{0,0,0,1,1, 32'h0,        5'd0, 5'd0, 32'h0,        4'hF};
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].d, 4'h0, tbl[i].l, tbl[i].nx, tbl[i].al, 0);
      chk("tbl_level", 32'(level), 32'(tbl[i].x_level));
      chk("tbl_bcnt", 32'(burst_cnt), 32'(tbl[i].x_bcnt));
      chk("tbl_data", app_wr_data, tbl[i].x_data);
      chk("tbl_en_n", 32'(app_wr_en_n), 32'(tbl[i].x_en));
      chk("tbl_errs", {30'h0, err_underrun, err_last_mis}, 32'h0);
    end

    // Fill to full, reject a 17th word, then one pop reopens the input.
    for (int i = 0; i < 16; i++) step(0, 1, 32'hA000_0000 + i, 4'(i), (i % 4) == 3, 0, 0, 0);
    chk("full_ready", 32'(ifc.wr_ready), 32'h0);
    step(0, 1, 32'hDEAD_BEEF, 4'h5, 1, 0, 0, 0);
    chk("full_ignore_level", 32'(level), 32'd16);
    pop_ok();
    chk("after_pop_ready", 32'(ifc.wr_ready), 32'h1);
    chk("after_pop_level", 32'(level), 32'd15);
    while (mq.size() != 0) pop_ok();

    // Underrun on empty, then clear.
    step(0, 0, 32'h0, 4'h0, 0, 1, 0, 0);
    chk("underrun_set", 32'(err_underrun), 32'h1);
    chk("underrun_level", 32'(level), 32'h0);
    chk("underrun_en_n", 32'(app_wr_en_n), 32'hF);
    step(0, 0, 32'h0, 4'h0, 0, 0, 0, 1);
    chk("underrun_clr", 32'(err_underrun), 32'h0);

    // Last-flag mismatch: burst count follows the stored flag.
    push(32'h5555_0001, 0);
    push(32'h5555_0002, 1);
    step(0, 0, 32'h0, 4'h0, 0, 1, 1, 0);
    chk("mis_set", 32'(err_last_mis), 32'h1);
    chk("mis_bcnt", 32'(burst_cnt), 32'h1);
    step(0, 0, 32'h0, 4'h0, 0, 1, 1, 0);
    chk("mis_bcnt_done", 32'(burst_cnt), 32'h0);
    step(0, 0, 32'h0, 4'h0, 0, 0, 0, 1);

    // Steady push+pop at level 8 across pointer wrap.
    for (int i = 0; i < 8; i++) push(32'hC000_0000 + i, (i % 4) == 3);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 32'hD000_0000 + i, 4'(i), (i % 4) == 3, 1, mq[0].last, 0);
      chk("wrap_level", 32'(level), 32'd8);
    end
    while (mq.size() != 0) pop_ok();

    // Reset in the middle of a burst with an error pending.
    step(0, 0, 32'h0, 4'h0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) push(32'hE000_0000 + i, 0);
    step(1, 0, 32'h0, 4'h0, 0, 0, 0, 0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_bcnt", 32'(burst_cnt), 32'h0);
    chk("rst_errs", {30'h0, err_underrun, err_last_mis}, 32'h0);
    chk("rst_ready", 32'(ifc.wr_ready), 32'h1);
    push(32'hF00D_CAFE, 1);
    chk("post_rst_bcnt", 32'(burst_cnt), 32'h1);
    chk("post_rst_head", app_wr_data, 32'hF00D_CAFE);
    pop_ok();
    chk("post_rst_empty", 32'(level), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit rr, vv, nn, aa, cc;
      rr = ($urandom % 150) == 0;
      vv = ($urandom % 4) != 0;
      nn = ($urandom % 3) != 0;
      cc = ($urandom % 16) == 0;
      if (mq.size() != 0 && ($urandom % 8) != 0) aa = mq[0].last;
      else aa = 1'($urandom % 2);
      step(rr, vv, $urandom, 4'($urandom), ($urandom % 4) == 0, nn, aa, cc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
